// File: rtl/int_injector.sv
// int_injector
//   Multi-channel interrupt stimulus generator. Each channel watches the
//   committed CPU PC, and when it reaches that channel's target PC it raises
//   its irq line, after an optional programmable delay. The line stays high
//   until the handler stores to the channel's acknowledge word.
//   Each channel also keeps a fire budget, a saturating count of acknowledged
//   fires, and a sticky error that flags an interrupt left unacknowledged.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   en             global arm enable (gates only IDLE -> WAIT/ASSERT)
//   clr            synchronous clear of all channel state, highest priority
//   cfg_target_pc  per-channel trigger PC, 32 bits each, bits [1:0] ignored
//   cfg_delay      per-channel delay from match to irq, DELAY_W bits each
//   macroscopic_pc committed PC from the CPU
//   m_int_addr     CPU memory-stage store address
//   m_int_byteen   CPU store byte enables (any nonzero pattern is a store)
//   irq            registered interrupt request lines
//   fire_cnt       per-channel acknowledged fire count, saturating
//   timeout_err    per-channel sticky timeout flag
//   busy           some channel is not IDLE
module int_injector #(
    parameter int unsigned N_CH      = 4,
    parameter logic [31:0] ACK_BASE  = 32'h0000_7f20,
    parameter int unsigned MAX_FIRES = 1,
    parameter int unsigned DELAY_W   = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clr,
    input  logic [N_CH*32-1:0]      cfg_target_pc,
    input  logic [N_CH*DELAY_W-1:0] cfg_delay,
    input  logic [31:0]             macroscopic_pc,
    input  logic [31:0]             m_int_addr,
    input  logic [3:0]              m_int_byteen,
    output logic [N_CH-1:0]         irq,
    output logic [N_CH*CNT_W-1:0]   fire_cnt,
    output logic [N_CH-1:0]         timeout_err,
    output logic                    busy
);

    localparam int unsigned    TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] FIRE_LIM = CNT_W'(MAX_FIRES);
    localparam bit               LIMITED  = (MAX_FIRES != 0);
    localparam bit               TO_ON    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ASSERT,
        ST_DONE
    } ch_state_t;

    ch_state_t          st_q  [N_CH];
    ch_state_t          st_d  [N_CH];
    logic [DELAY_W-1:0] dly_q [N_CH];
    logic [DELAY_W-1:0] dly_d [N_CH];
    logic [TO_W-1:0]    to_q  [N_CH];
    logic [TO_W-1:0]    to_d  [N_CH];
    logic [CNT_W-1:0]   cnt_q [N_CH];
    logic [CNT_W-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0]    err_q, err_d;
    logic [N_CH-1:0]    irq_q, irq_d;
    logic [N_CH-1:0]    match, ack;

    // Word-aligned compares: the low two address bits never take part.
    always_comb begin
        match = '0;
        ack   = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            match[c] = (macroscopic_pc[31:2] == cfg_target_pc[32*c+2 +: 30]);
            ack[c]   = (|m_int_byteen) &&
                       (m_int_addr[31:2] == ACK_BASE[31:2] + 30'(c));
        end
    end

    always_comb begin
        err_d = err_q;
        irq_d = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            st_d[c]  = st_q[c];
            dly_d[c] = dly_q[c];
            to_d[c]  = to_q[c];
            cnt_d[c] = cnt_q[c];
            if (clr) begin
                st_d[c]  = ST_IDLE;
                dly_d[c] = '0;
                to_d[c]  = '0;
                cnt_d[c] = '0;
                err_d[c] = 1'b0;
            end else begin
                case (st_q[c])
                    ST_IDLE: begin
                        if (en && match[c] && (!LIMITED || cnt_q[c] < FIRE_LIM)) begin
                            dly_d[c] = cfg_delay[c*DELAY_W +: DELAY_W];
                            to_d[c]  = '0;
                            // Delay 0 skips WAIT so irq rises one cycle after the match.
                            st_d[c]  = (dly_d[c] == '0) ? ST_ASSERT : ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (dly_q[c] == DELAY_W'(1)) begin
                            dly_d[c] = '0;
                            st_d[c]  = ST_ASSERT;
                        end else begin
                            dly_d[c] = dly_q[c] - 1'b1;
                        end
                    end
                    ST_ASSERT: begin
                        if (ack[c]) begin
                            cnt_d[c] = (&cnt_q[c]) ? cnt_q[c] : cnt_q[c] + 1'b1;
                            to_d[c]  = '0;
                            st_d[c]  = (LIMITED && cnt_d[c] == FIRE_LIM) ? ST_DONE : ST_IDLE;
                        end else if (TO_ON && to_q[c] != TO_LIM) begin
                            to_d[c] = to_q[c] + 1'b1;
                            if (to_d[c] == TO_LIM) begin
                                err_d[c] = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            irq_d[c] = (st_d[c] == ST_ASSERT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                st_q[c]  <= ST_IDLE;
                dly_q[c] <= '0;
                to_q[c]  <= '0;
                cnt_q[c] <= '0;
            end
            err_q <= '0;
            irq_q <= '0;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                st_q[c]  <= st_d[c];
                dly_q[c] <= dly_d[c];
                to_q[c]  <= to_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            err_q <= err_d;
            irq_q <= irq_d;
        end
    end

    always_comb begin
        busy     = 1'b0;
        fire_cnt = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (st_q[c] != ST_IDLE) begin
                busy = 1'b1;
            end
            fire_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
        end
    end

    assign irq         = irq_q;
    assign timeout_err = err_q;

endmodule
